// File: rtl/mult_div_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encodings,
// FSM states and iteration-counter width.
package mdu_pkg;

   localparam int MDU_WIDTH  = 32;
   localparam int MDU_ITER_W = $clog2(MDU_WIDTH + 1);

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5,
      MDU_NOP6  = 3'd6,
      MDU_NOP7  = 3'd7
   } mdu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The divz flag exists only when MDU_DIVZ_FLAG_EN is defined.
interface mult_div_unit_if
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
);

   logic             start;
   mdu_op_t          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
`ifdef MDU_DIVZ_FLAG_EN
   logic             divz;

   modport master (output start, op, a, b, cancel, input busy, done, hi, lo, divz);
   modport slave  (input start, op, a, b, cancel, output busy, done, hi, lo, divz);
`else
   modport master (output start, op, a, b, cancel, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, cancel, output busy, done, hi, lo);
`endif

endinterface

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract the
// divisor when it fits, producing one quotient bit.
module mdu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             bit_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_o
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   // The extra top bit of diff acts as the borrow: clear means the divisor fit.
   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {2'b00, divisor_i};
   assign q_o     = ~diff[WIDTH+1];
   assign rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Define MDU_DIVZ_FLAG_EN to short-circuit divide-by-zero and flag it on divz.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input logic            clk,
   input logic            rst_n,
   mult_div_unit_if.slave bus
);

   localparam int IterW = $clog2(WIDTH + 1);

   mdu_state_e         state_q, state_d;
   logic [IterW-1:0]   cnt_q, cnt_d;
   logic               isDiv_q, isDiv_d;
   logic               negRes_q, negRes_d;
   logic               negRem_q, negRem_d;
   logic [WIDTH-1:0]   opB_q, opB_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
`ifdef MDU_DIVZ_FLAG_EN
   logic               divzRun_q, divzRun_d;
   logic               divz_q, divz_d;
`endif

   logic               isSigned;
   logic               aNeg, bNeg;
   logic [WIDTH-1:0]   aMag, bMag;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     divRem;
   logic               divBit;
   logic [2*WIDTH-1:0] prodRes;
   logic [WIDTH-1:0]   quotRes, remRes;

   assign isSigned = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
   assign aNeg     = isSigned & bus.a[WIDTH-1];
   assign bNeg     = isSigned & bus.b[WIDTH-1];
   assign aMag     = aNeg ? (~bus.a + 1'b1) : bus.a;
   assign bMag     = bNeg ? (~bus.b + 1'b1) : bus.b;

   // acc holds {partial product, remaining multiplier bits} while multiplying,
   // and the dividend shifting out / quotient shifting in while dividing.
   assign mulSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opB_q} : '0);

   mdu_div_step #(.WIDTH(WIDTH)) u_divStep (
      .rem_i     (rem_q),
      .divisor_i (opB_q),
      .bit_i     (acc_q[WIDTH-1]),
      .rem_o     (divRem),
      .q_o       (divBit)
   );

   assign prodRes = negRes_q ? (~acc_q + 1'b1) : acc_q;
   assign quotRes = negRes_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
   assign remRes  = negRem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      isDiv_d  = isDiv_q;
      negRes_d = negRes_q;
      negRem_d = negRem_q;
      opB_d    = opB_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
`ifdef MDU_DIVZ_FLAG_EN
      divzRun_d = divzRun_q;
      divz_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                     state_d  = ST_CALC;
                     cnt_d    = '0;
                     isDiv_d  = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
                     negRes_d = aNeg ^ bNeg;
                     negRem_d = aNeg;
                     opB_d    = bMag;
                     acc_d    = {{WIDTH{1'b0}}, aMag};
                     rem_d    = '0;
`ifdef MDU_DIVZ_FLAG_EN
                     divzRun_d = ((bus.op == MDU_DIV) || (bus.op == MDU_DIVU)) && (bus.b == '0);
                     if (divzRun_d) begin
                        state_d = ST_FIX;
                     end
`endif
                  end
                  MDU_MTHI: hi_d = bus.a;
                  MDU_MTLO: lo_d = bus.a;
                  default: ;
               endcase
            end
         end
         ST_CALC: begin
            if (bus.cancel) begin
               state_d = ST_IDLE;
            end else begin
               if (isDiv_q) begin
                  rem_d = divRem;
                  acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], divBit};
               end else begin
                  acc_d = {mulSum, acc_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == IterW'(WIDTH - 1)) begin
                  state_d = ST_FIX;
               end
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            if (!bus.cancel) begin
               done_d = 1'b1;
`ifdef MDU_DIVZ_FLAG_EN
               if (divzRun_q) begin
                  divz_d = 1'b1;
               end else
`endif
               if (isDiv_q) begin
                  hi_d = remRes;
                  lo_d = quotRes;
               end else begin
                  {hi_d, lo_d} = prodRes;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         isDiv_q  <= 1'b0;
         negRes_q <= 1'b0;
         negRem_q <= 1'b0;
         opB_q    <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
`ifdef MDU_DIVZ_FLAG_EN
         divzRun_q <= 1'b0;
         divz_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         isDiv_q  <= isDiv_d;
         negRes_q <= negRes_d;
         negRem_q <= negRem_d;
         opB_q    <= opB_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
`ifdef MDU_DIVZ_FLAG_EN
         divzRun_q <= divzRun_d;
         divz_q    <= divz_d;
`endif
      end
   end

   assign bus.busy = (state_q != ST_IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
`ifdef MDU_DIVZ_FLAG_EN
   assign bus.divz = divz_q;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push expected HI/LO
// and completion edge; a monitor pops and compares on every done pulse.
module tb_mult_div_unit;
   import mdu_pkg::*;

   localparam int W       = 32;
   localparam int LAT     = W + 1;
   localparam int DIVZLAT = 1;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        divz;
      int          edgeNo;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mult_div_unit_if #(.WIDTH(W)) bus ();

   mult_div_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t        expQ[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          edgeCount = 0;
   logic [31:0] modelHi = '0;
   logic [31:0] modelLo = '0;

   always @(posedge clk) edgeCount++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
      end
   endtask

   // Issue one request at the current negedge; results are only queued when a done is due.
   task automatic applyStimulus(input string name, input mdu_op_t op, input logic [31:0] a,
                                input logic [31:0] b, input logic push, input logic [31:0] eHi,
                                input logic [31:0] eLo, input logic eDivz, input int lat);
      exp_t e;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      if (push) begin
         e.name   = name;
         e.hi     = eHi;
         e.lo     = eLo;
         e.divz   = eDivz;
         e.edgeNo = edgeCount + 1 + lat;
         expQ.push_back(e);
         modelHi = eHi;
         modelLo = eLo;
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic waitDrain(input string name, input int limit);
      int n = 0;
      while (expQ.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL %s.timeout: got %0d pending, expected 0", name, expQ.size());
         expQ.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic waitEdge(input int target);
      while (edgeCount < target) @(negedge clk);
   endtask

   task automatic runOp(input string name, input mdu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo);
      applyStimulus(name, op, a, b, 1'b1, eHi, eLo, 1'b0, LAT);
      waitDrain(name, LAT + 10);
   endtask

   // Divide by zero: flagged bypass when the option is built in, full iteration otherwise.
   task automatic runDivZero(input string name, input mdu_op_t op, input logic [31:0] a,
                             input logic [31:0] offHi, input logic [31:0] offLo);
`ifdef MDU_DIVZ_FLAG_EN
      applyStimulus(name, op, a, 32'h0, 1'b1, modelHi, modelLo, 1'b1, DIVZLAT);
`else
      applyStimulus(name, op, a, 32'h0, 1'b1, offHi, offLo, 1'b0, LAT);
`endif
      waitDrain(name, LAT + 10);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.done) begin
            checkOutput("done_vs_busy", {31'b0, bus.busy}, 32'h0);
            if (expQ.size() == 0) begin
               checkOutput("spurious_done", {31'b0, bus.done}, 32'h0);
            end else begin
               e = expQ.pop_front();
               checkOutput({e.name, ".hi"}, bus.hi, e.hi);
               checkOutput({e.name, ".lo"}, bus.lo, e.lo);
               checkOutput({e.name, ".edge"}, 32'(edgeCount), 32'(e.edgeNo));
`ifdef MDU_DIVZ_FLAG_EN
               checkOutput({e.name, ".divz"}, {31'b0, bus.divz}, {31'b0, e.divz});
`endif
            end
         end
`ifdef MDU_DIVZ_FLAG_EN
         if (bus.divz && !bus.done) checkOutput("divz_without_done", 32'h1, 32'h0);
`endif
      end
   end

   initial begin
      int n;
      bus.start  = 1'b0;
      bus.op     = MDU_MULT;
      bus.a      = '0;
      bus.b      = '0;
      bus.cancel = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset.busy", {31'b0, bus.busy}, 32'h0);
      checkOutput("reset.done", {31'b0, bus.done}, 32'h0);
      checkOutput("reset.hi", bus.hi, 32'h0);
      checkOutput("reset.lo", bus.lo, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      runOp("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      runOp("mult_neg", MDU_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
      runOp("mult_negneg", MDU_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0, 32'h0000001E);
      runOp("multu_shift", MDU_MULTU, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780);
      runOp("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      runOp("div_negdivisor", MDU_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      runOp("div_overflow", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
      runOp("divu", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      runDivZero("divu_zero", MDU_DIVU, 32'd5, 32'd5, 32'hFFFFFFFF);
      runDivZero("div_zero_neg", MDU_DIV, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000001);

      // MTHI / MTLO write at the start edge without becoming busy.
      bus.start = 1'b1; bus.op = MDU_MTHI; bus.a = 32'h1234;
      @(negedge clk);
      bus.op = MDU_MTLO; bus.a = 32'h5678;
      checkOutput("mthi.hi", bus.hi, 32'h1234);
      checkOutput("mthi.busy", {31'b0, bus.busy}, 32'h0);
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("mtlo.lo", bus.lo, 32'h5678);
      checkOutput("mtlo.hi", bus.hi, 32'h1234);
      modelHi = 32'h1234;
      modelLo = 32'h5678;

      // Reserved op is ignored.
      bus.start = 1'b1; bus.op = MDU_NOP6; bus.a = 32'hDEADBEEF;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("nop.busy", {31'b0, bus.busy}, 32'h0);
      checkOutput("nop.hi", bus.hi, modelHi);
      checkOutput("nop.lo", bus.lo, modelLo);

      // Cancel in CALC, with an ignored start along the way.
      n = edgeCount;
      applyStimulus("cancel_calc", MDU_MULT, 32'd3, 32'd4, 1'b0, '0, '0, 1'b0, LAT);
      waitEdge(n + 5);
      bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 32'd1; bus.b = 32'd1;
      @(negedge clk);
      bus.start = 1'b0;
      waitEdge(n + 10);
      checkOutput("cancel_calc.busy_before", {31'b0, bus.busy}, 32'h1);
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
      checkOutput("cancel_calc.busy_after", {31'b0, bus.busy}, 32'h0);
      checkOutput("cancel_calc.hi", bus.hi, 32'h1234);
      checkOutput("cancel_calc.lo", bus.lo, 32'h5678);
      repeat (40) @(negedge clk);

      // Start while busy is dropped; the running op keeps its timing and result.
      n = edgeCount;
      applyStimulus("busy_ignore", MDU_MULTU, 32'd3, 32'd5, 1'b1, 32'h0, 32'd15, 1'b0, LAT);
      waitEdge(n + 5);
      bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 32'd100; bus.b = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      waitDrain("busy_ignore", LAT + 10);

      // Cancel arriving in FIX wins over the write-back.
      n = edgeCount;
      applyStimulus("cancel_fix", MDU_MULTU, 32'd2, 32'd2, 1'b0, '0, '0, 1'b0, LAT);
      waitEdge(n + 33);
      checkOutput("cancel_fix.busy_before", {31'b0, bus.busy}, 32'h1);
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
      checkOutput("cancel_fix.busy_after", {31'b0, bus.busy}, 32'h0);
      checkOutput("cancel_fix.lo", bus.lo, modelLo);
      repeat (5) @(negedge clk);

      // Cancel alongside a start in IDLE does not block the start.
      bus.cancel = 1'b1;
      applyStimulus("cancel_idle_start", MDU_MULTU, 32'd6, 32'd7, 1'b1, 32'h0, 32'd42, 1'b0, LAT);
      bus.cancel = 1'b0;
      waitDrain("cancel_idle_start", LAT + 10);

      // Asynchronous reset in the middle of a divide.
      n = edgeCount;
      applyStimulus("reset_mid", MDU_DIV, 32'hFFFFFF9C, 32'd7, 1'b0, '0, '0, 1'b0, LAT);
      waitEdge(n + 20);
      rst_n = 1'b0;
      #1;
      checkOutput("reset_mid.busy", {31'b0, bus.busy}, 32'h0);
      checkOutput("reset_mid.done", {31'b0, bus.done}, 32'h0);
      checkOutput("reset_mid.hi", bus.hi, 32'h0);
      checkOutput("reset_mid.lo", bus.lo, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      modelHi = '0;
      modelLo = '0;
      @(negedge clk);
      runOp("after_reset", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
